ahb_lite_master: RTL and testbench

AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

---
 rtl/ahb_pkg.sv | 19 +
 rtl/ahb_wait_timer.sv | 20 ++
 rtl/ahb_lite_master.sv | 128 ++++++++++++
 tb/tb_ahb_lite_master.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite transfer, size, burst and protection codes shared by the master.
package ahb_pkg;
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;
    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;
    function automatic logic [2:0] hsize_of(input logic [2:0] sz);
        return sz & 3'b011;
    endfunction
endpackage

// File: rtl/ahb_wait_timer.sv
// ahb_wait_timer: counts consecutive stalled data-phase cycles; expired marks the last allowed one.
module ahb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic HCLK,
    input  logic HRESET,
    input  logic enable,
    input  logic HREADY,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    logic [W-1:0] r_cnt;
    logic         w_stall;
    assign w_stall = enable && !HREADY;
    assign expired = w_stall && (r_cnt == W'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) r_cnt <= '0;
        else        r_cnt <= w_stall ? r_cnt + 1'b1 : '0;
    end
endmodule

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: single-transfer AHB-Lite initiator with a pipelined command/response interface.
// Defining AHB_MASTER_TIMEOUT_EN adds a sticky data-phase timeout via ahb_wait_timer.
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic        cmd_write,
    input  logic [2:0]  cmd_size,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        timeout,
    output logic [31:0] HADDR,
    output logic [31:0] HWDATA,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);
    logic        r_live;
    logic        r_addr_pend;
    logic        r_data_pend;
    logic        r_data_write;
    logic        r_hwrite;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    htrans_e     r_htrans;
    logic [2:0]  r_hsize;
    logic [31:0] r_haddr;
    logic [31:0] r_wdata;
    logic [31:0] r_hwdata;
    logic [31:0] r_rsp_rdata;
    logic        w_accept;
    logic        w_addr_done;
    logic        w_data_done;
    logic        w_expired;

`ifdef AHB_MASTER_TIMEOUT_EN
    logic r_timeout;
    ahb_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .enable  (r_data_pend),
        .HREADY  (HREADY),
        .expired (w_expired)
    );
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)         r_timeout <= 1'b0;
        else if (w_expired) r_timeout <= 1'b1;
    end
    assign timeout = r_timeout;
`else
    assign w_expired = 1'b0;
    assign timeout   = 1'b0;
`endif

    // r_live keeps cmd_ready low until the first edge after reset release
    assign cmd_ready   = r_live && !timeout && (!r_addr_pend || HREADY);
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_addr_done = r_addr_pend && HREADY;
    assign w_data_done = r_data_pend && HREADY;

    assign HADDR     = r_haddr;
    assign HWDATA    = r_hwdata;
    assign HTRANS    = r_htrans;
    assign HWRITE    = r_hwrite;
    assign HSIZE     = r_hsize;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DEFAULT;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_live       <= 1'b0;
            r_addr_pend  <= 1'b0;
            r_data_pend  <= 1'b0;
            r_data_write <= 1'b0;
            r_hwrite     <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_htrans     <= HTRANS_IDLE;
            r_hsize      <= 3'b000;
            r_haddr      <= '0;
            r_wdata      <= '0;
            r_hwdata     <= '0;
            r_rsp_rdata  <= '0;
        end else begin
            r_live      <= 1'b1;
            r_rsp_valid <= w_data_done || w_expired;
            r_rsp_err   <= (w_data_done && HRESP) || w_expired;
            r_rsp_rdata <= (w_data_done && !r_data_write && !HRESP) ? HRDATA : '0;
            if (w_expired) begin
                r_data_pend <= 1'b0;
            end else if (w_addr_done) begin
                r_data_pend  <= 1'b1;
                r_data_write <= r_hwrite;
                r_hwdata     <= r_wdata;
            end else if (w_data_done) begin
                r_data_pend <= 1'b0;
            end
            // an error in the data phase does not touch a pending address phase
            if (w_accept) begin
                r_addr_pend <= 1'b1;
                r_htrans    <= HTRANS_NONSEQ;
                r_haddr     <= cmd_addr;
                r_hwrite    <= cmd_write;
                r_hsize     <= hsize_of(cmd_size);
                r_wdata     <= cmd_wdata;
            end else if (w_addr_done || w_expired) begin
                r_addr_pend <= 1'b0;
                r_htrans    <= HTRANS_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: randomized scoreboard bench with a behavioural AHB responder model.
module tb_ahb_lite_master;
`ifdef AHB_MASTER_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        write;
        logic [2:0]  size;
        int          waits;
        bit          err;
    } plan_t;
    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        cmd_write = 1'b0;
    logic [2:0]  cmd_size = '0;
    logic        rsp_valid, rsp_err, timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HRDATA = '0;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;

    plan_t pl_q[$];
    exp_t  ex_q[$];
    exp_t  mx;
    int    n_chk = 0;
    int    n_pass = 0;
    int    cyc = 0;

    ahb_lite_master #(.TIMEOUT_CYCLES(TO)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_write(cmd_write), .cmd_size(cmd_size),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .timeout(timeout),
        .HADDR(HADDR), .HWDATA(HWDATA), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%0h want=%0h at cycle %0d", nm, got, want, cyc);
    endtask

    // Responder model: each accepted command carries its own plan (waits, error, read data)
    initial begin : responder
        bit          dp, pr, pn, pw;
        int          cnt;
        plan_t       cur;
        logic [31:0] pa;
        logic [2:0]  ps;
        dp = 0; pr = 0; pn = 0; pw = 0; cnt = 0; pa = '0; ps = '0;
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                dp = 0; pr = 0; pn = 0;
                HREADY = 1'b1; HRESP = 1'b0;
            end else begin
                if (pr) begin
                    dp = 0;
                    if (pn) begin
                        if (pl_q.size() == 0) chk("spurious_xfer", 1, 0);
                        else begin
                            cur = pl_q.pop_front();
                            chk("haddr", pa, cur.addr);
                            chk("hwrite", pw, cur.write);
                            chk("hsize", ps, {1'b0, cur.size[1:0]});
                            dp = 1; cnt = 0;
                        end
                    end
                end else begin
                    if (dp) cnt++;
                    if (pn) chk("addr_hold", {HTRANS, HADDR, HWRITE, HSIZE}, {2'b10, pa, pw, ps});
                end
                if (!dp) begin
                    HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
                end else if (cnt < cur.waits) begin
                    HREADY = 1'b0; HRESP = 1'b0; HRDATA = $urandom;
                end else if (cur.err && cnt == cur.waits) begin
                    HREADY = 1'b0; HRESP = 1'b1;
                end else begin
                    HREADY = 1'b1; HRESP = cur.err;
                    HRDATA = cur.err ? $urandom : cur.rdata;
                    if (cur.write) chk("hwdata", HWDATA, cur.wdata);
                end
                pr = HREADY; pn = (HTRANS == 2'b10); pa = HADDR; pw = HWRITE; ps = HSIZE;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge HCLK);
            if (rsp_valid) begin
                if (ex_q.size() == 0) chk("rsp_spurious", 1, 0);
                else begin
                    mx = ex_q.pop_front();
                    chk("rsp_err", rsp_err, mx.err);
                    chk("rsp_rdata", rsp_rdata, mx.rdata);
                    if (mx.due >= 0) chk("rsp_cycle", cyc, mx.due);
                end
            end
        end
    end

    // lat < 0 skips the latency check (used where earlier traffic shifts timing)
    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic w,
                         input logic [2:0] sz, input int wt, input bit e,
                         input logic [31:0] rd, input int lat);
        plan_t p;
        exp_t  x;
        int    n;
        p.addr = a; p.wdata = wd; p.rdata = rd; p.write = w; p.size = sz; p.waits = wt; p.err = e;
        cmd_valid = 1'b1; cmd_addr = a; cmd_wdata = wd; cmd_write = w; cmd_size = sz;
        n = 0;
        forever begin
            @(negedge HCLK); #1;
            if (cmd_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_wait", 0, 1);
                cmd_valid = 1'b0;
                return;
            end
            @(posedge HCLK); #1;
        end
        x.err = e;
        x.rdata = (w || e) ? 32'h0 : rd;
        x.due = (lat < 0) ? -1 : cyc + lat;
        pl_q.push_back(p);
        ex_q.push_back(x);
        @(posedge HCLK); #1;
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic drain();
        int n;
        cmd_valid = 1'b0;
        n = 0;
        while (ex_q.size() != 0 && n < 500) begin
            @(posedge HCLK);
            n++;
        end
        chk("drain", ex_q.size(), 0);
        repeat (2) @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        cmd_valid = 1'b0;
        pl_q.delete();
        ex_q.delete();
        @(negedge HCLK);
        chk("rst_outs", {HTRANS, HADDR, HWDATA, HWRITE, HSIZE, cmd_ready, rsp_valid,
                         rsp_err, rsp_rdata, timeout}, 0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(posedge HCLK);
        @(negedge HCLK); #1;
        chk("ready_after_rst", cmd_ready, 1);
        chk("hburst_hprot", {HBURST, HPROT}, {3'b000, 4'b0011});
        @(posedge HCLK); #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : main
        repeat (3) @(posedge HCLK);
        #1;
        do_reset();

        issue(32'h5000_0004, 32'hDEAD_BEEF, 1'b1, 3'd2, 0, 1'b0, 32'h0, 3);
        drain();

        for (int i = 0; i < 4; i++)
            issue(32'h100 + 32'(4 * i), 32'h0, 1'b0, 3'd2, 0, 1'b0, 32'(i), 3);
        drain();

        issue(32'h200, 32'h0, 1'b0, 3'd2, 3, 1'b0, $urandom, 6);
        issue(32'h204, 32'h0, 1'b0, 3'd1, 0, 1'b0, $urandom, -1);
        drain();

        issue(32'h300, 32'h0, 1'b0, 3'd2, 0, 1'b1, $urandom, 4);
        issue(32'h304, 32'h1234_5678, 1'b1, 3'd0, 0, 1'b0, 32'h0, -1);
        drain();

        issue(32'h400, 32'h0, 1'b0, 3'd2, 20, 1'b0, $urandom, -1);
        cmd_valid = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        do_reset();

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(3) == 0) idle($urandom_range(3, 1));
            issue($urandom, $urandom, 1'($urandom), 3'($urandom_range(2)),
                  $urandom_range(3), ($urandom_range(7) == 0), $urandom, -1);
        end
        drain();

`ifdef AHB_MASTER_TIMEOUT_EN
        issue(32'h600, 32'h0, 1'b0, 3'd2, 1000, 1'b0, 32'h0, 10);
        ex_q[ex_q.size() - 1].err = 1'b1;
        cmd_valid = 1'b0;
        repeat (14) @(posedge HCLK);
        #1;
        chk("timeout_flag", timeout, 1);
        chk("timeout_rsp_count", ex_q.size(), 0);
        cmd_valid = 1'b1;
        cmd_addr = 32'h700;
        for (int i = 0; i < 5; i++) begin
            @(negedge HCLK); #1;
            chk("timeout_ready", {cmd_ready, HTRANS, timeout}, {1'b0, 2'b00, 1'b1});
        end
        cmd_valid = 1'b0;
        @(posedge HCLK); #1;
        do_reset();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
